// File: rtl/xy_route_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : xy_route_dispatch
// Brief    : Output-dispatch stage of a mesh NoC router. Pops packets from a
//            show-ahead FIFO, picks the output port by dimension-ordered
//            routing (XY or YX), holds the packet with a one-hot request
//            until the matching grant, drops packets addressed outside the
//            mesh and keeps dispatched / dropped packet counters.
// Revision : 1.0 - initial release
// ============================================================================
module xy_route_dispatch #(
    parameter int DW      = 32,
    parameter int CW      = 2,
    parameter int X_LSB   = 0,
    parameter int Y_LSB   = 2,
    parameter int POS_X   = 1,
    parameter int POS_Y   = 1,
    parameter int MESH_X  = 4,
    parameter int MESH_Y  = 4,
    parameter bit YX_MODE = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] fifo_data,
    input  logic          fifo_empty,
    output logic          rdreq,
    output logic [DW-1:0] data_out,
    output logic [4:0]    req,
    input  logic [4:0]    gnt,
    output logic          drop_pulse,
    output logic [15:0]   pkt_cnt,
    output logic [7:0]    drop_cnt
);

    // State encoding
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    // One-hot direction encoding {L,N,E,S,W}
    localparam logic [4:0] c_dir_l = 5'b10000;
    localparam logic [4:0] c_dir_n = 5'b01000;
    localparam logic [4:0] c_dir_e = 5'b00100;
    localparam logic [4:0] c_dir_s = 5'b00010;
    localparam logic [4:0] c_dir_w = 5'b00001;

    // Coordinates and mesh bounds widened to 32 bits for unsigned compares
    localparam logic [31:0] c_pos_x  = 32'(POS_X);
    localparam logic [31:0] c_pos_y  = 32'(POS_Y);
    localparam logic [31:0] c_mesh_x = 32'(MESH_X);
    localparam logic [31:0] c_mesh_y = 32'(MESH_Y);

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          w_grant;
    logic          w_load;
    logic          w_drop;
    logic [4:0]    w_route;
    logic [4:0]    w_req_nxt;
    logic [31:0]   w_dx;
    logic [31:0]   w_dy;
    logic          w_x_gt;
    logic          w_x_lt;
    logic          w_y_gt;
    logic          w_y_lt;

    // Destination fields of the FIFO head word
    assign w_dx = 32'(fifo_data[X_LSB +: CW]);
    assign w_dy = 32'(fifo_data[Y_LSB +: CW]);

    assign w_x_gt = (w_dx > c_pos_x);
    assign w_x_lt = (w_dx < c_pos_x);
    assign w_y_gt = (w_dy > c_pos_y);
    assign w_y_lt = (w_dy < c_pos_y);

    // Out-of-mesh destinations are popped and discarded
    assign w_drop = (w_dx >= c_mesh_x) || (w_dy >= c_mesh_y);

    // A held packet completes when the arbiter grants exactly what we request
    assign w_grant = (r_state == c_st_hold) && (gnt == req);

    // The head word is stale while rdreq is high, so never load in that cycle
    assign w_load = !fifo_empty && !rdreq &&
                    ((r_state == c_st_idle) || w_grant);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: load wins over completion, drops return to idle
    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = w_drop ? c_st_idle : c_st_hold;
        end else if (w_grant) begin
            w_state_nxt = c_st_idle;
        end
    end

    // Output decode: dimension-ordered route and the next request vector
    always_comb begin
        w_route = c_dir_l;
        if (YX_MODE) begin
            if (w_y_gt)      w_route = c_dir_n;
            else if (w_y_lt) w_route = c_dir_s;
            else if (w_x_gt) w_route = c_dir_e;
            else if (w_x_lt) w_route = c_dir_w;
        end else begin
            if (w_x_gt)      w_route = c_dir_e;
            else if (w_x_lt) w_route = c_dir_w;
            else if (w_y_gt) w_route = c_dir_n;
            else if (w_y_lt) w_route = c_dir_s;
        end

        w_req_nxt = req;
        if (w_load) begin
            w_req_nxt = w_drop ? 5'b00000 : w_route;
        end else if (w_grant) begin
            w_req_nxt = 5'b00000;
        end
    end

    // Registered outputs: pop pulse, held packet, request, drop pulse, counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdreq      <= 1'b0;
            data_out   <= '0;
            req        <= 5'b00000;
            drop_pulse <= 1'b0;
            pkt_cnt    <= 16'd0;
            drop_cnt   <= 8'd0;
        end else begin
            rdreq      <= w_load;
            drop_pulse <= w_load && w_drop;
            req        <= w_req_nxt;
            if (w_load) begin
                data_out <= fifo_data;
            end
            if (w_grant) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (w_load && w_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xy_route_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_xy_route_dispatch
// Brief    : Self-checking bench for xy_route_dispatch. Two instances: an XY
//            router in a 4x4 mesh and a YX router in a 3x4 mesh, both at
//            (1,1). A transaction-level reference model owns each FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xy_route_dispatch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [31:0] fifo_data0 = 32'h0, fifo_data1 = 32'h0;
    logic        fifo_empty0 = 1'b1, fifo_empty1 = 1'b1;
    logic [4:0]  gnt0 = 5'b0, gnt1 = 5'b0;
    logic        rdreq0, rdreq1;
    logic [31:0] data_out0, data_out1;
    logic [4:0]  req0, req1;
    logic        drop_pulse0, drop_pulse1;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic [7:0]  drop_cnt0, drop_cnt1;

    xy_route_dispatch #(
        .DW(32), .CW(2), .X_LSB(0), .Y_LSB(2), .POS_X(1), .POS_Y(1),
        .MESH_X(4), .MESH_Y(4), .YX_MODE(1'b0)
    ) u_dut_xy (
        .clk(clk), .reset_n(reset_n),
        .fifo_data(fifo_data0), .fifo_empty(fifo_empty0), .rdreq(rdreq0),
        .data_out(data_out0), .req(req0), .gnt(gnt0), .drop_pulse(drop_pulse0),
        .pkt_cnt(pkt_cnt0), .drop_cnt(drop_cnt0)
    );

    xy_route_dispatch #(
        .DW(32), .CW(2), .X_LSB(0), .Y_LSB(2), .POS_X(1), .POS_Y(1),
        .MESH_X(3), .MESH_Y(4), .YX_MODE(1'b1)
    ) u_dut_yx (
        .clk(clk), .reset_n(reset_n),
        .fifo_data(fifo_data1), .fifo_empty(fifo_empty1), .rdreq(rdreq1),
        .data_out(data_out1), .req(req1), .gnt(gnt1), .drop_pulse(drop_pulse1),
        .pkt_cnt(pkt_cnt1), .drop_cnt(drop_cnt1)
    );

    always #5 clk = ~clk;

    // Direction one-hots {L,N,E,S,W}
    localparam logic [4:0] c_l = 5'b10000, c_n = 5'b01000, c_e = 5'b00100,
                           c_s = 5'b00010, c_w = 5'b00001;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO contents per instance (ring buffer)
    logic [31:0] fmem [2][512];
    int          fhead [2];
    int          fcnt  [2];

    // Reference model of each instance's visible outputs
    bit          m_hold [2];
    logic [4:0]  m_req  [2];
    logic [31:0] m_data [2];
    bit          m_rd   [2];
    bit          m_drop [2];
    logic [15:0] m_pkt  [2];
    logic [7:0]  m_dcnt [2];

    // Grant policy: 0 random, 1 grant whatever is requested, 2 fixed gfix
    int          gmode [2];
    logic [4:0]  gfix  [2];

    int          cyc = 0;
    int          rd_seen [2];
    int          drop_seen [2];
    bit          capture = 1'b0;
    logic [4:0]  cap_req [$];
    int          cap_cyc [$];

    int          xy_dx [5] = '{3, 0, 1, 1, 1};
    int          xy_dy [5] = '{0, 3, 3, 0, 1};
    logic [4:0]  xy_exp [5];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int mesh_x(int i);
        return (i == 0) ? 4 : 3;
    endfunction

    // Dimension-ordered routing from (1,1), expressed as signed hop offsets
    function automatic logic [4:0] route(int dx, int dy, int i);
        int ox, oy;
        ox = dx - 1;
        oy = dy - 1;
        if (i == 1) begin
            if (oy != 0) return (oy > 0) ? c_n : c_s;
            if (ox != 0) return (ox > 0) ? c_e : c_w;
        end else begin
            if (ox != 0) return (ox > 0) ? c_e : c_w;
            if (oy != 0) return (oy > 0) ? c_n : c_s;
        end
        return c_l;
    endfunction

    function automatic logic [31:0] mkpkt(int dx, int dy);
        logic [31:0] p;
        p = $urandom;
        p[1:0] = 2'(dx);
        p[3:2] = 2'(dy);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hold[i] = 1'b0; m_req[i] = 5'b0; m_data[i] = 32'h0;
            m_rd[i] = 1'b0; m_drop[i] = 1'b0; m_pkt[i] = 16'h0; m_dcnt[i] = 8'h0;
        end
    endtask

    // Advance instance i by one clock given the grant it saw
    task automatic model_update(int i, logic [4:0] g);
        bit grant, load;
        logic [31:0] h;
        int dx, dy;
        if (!reset_n) begin
            model_reset();
            return;
        end
        grant = m_hold[i] && (g == m_req[i]);
        load  = (fcnt[i] != 0) && !m_rd[i] && (!m_hold[i] || grant);
        m_rd[i]   = load;
        m_drop[i] = 1'b0;
        if (grant) m_pkt[i] = m_pkt[i] + 16'd1;
        if (load) begin
            h = fmem[i][fhead[i]];
            fhead[i] = (fhead[i] + 1) % 512;
            fcnt[i]--;
            m_data[i] = h;
            dx = int'(h[1:0]);
            dy = int'(h[3:2]);
            if (dx >= mesh_x(i) || dy >= 4) begin
                m_drop[i] = 1'b1;
                if (m_dcnt[i] != 8'hFF) m_dcnt[i] = m_dcnt[i] + 8'd1;
                m_req[i]  = 5'b0;
                m_hold[i] = 1'b0;
            end else begin
                m_req[i]  = route(dx, dy, i);
                m_hold[i] = 1'b1;
            end
        end else if (grant) begin
            m_req[i]  = 5'b0;
            m_hold[i] = 1'b0;
        end
    endtask

    task automatic drive();
        logic [4:0] g [2];
        int r;
        for (int i = 0; i < 2; i++) begin
            case (gmode[i])
                1: g[i] = m_req[i];
                2: g[i] = gfix[i];
                default: begin
                    r = $urandom_range(0, 99);
                    if (r < 60)      g[i] = m_req[i];
                    else if (r < 80) g[i] = 5'(1 << $urandom_range(0, 4));
                    else             g[i] = 5'b0;
                end
            endcase
        end
        gnt0 = g[0];
        gnt1 = g[1];
        fifo_empty0 = (fcnt[0] == 0);
        fifo_empty1 = (fcnt[1] == 0);
        if (fcnt[0] != 0) fifo_data0 = fmem[0][fhead[0]];
        if (fcnt[1] != 0) fifo_data1 = fmem[1][fhead[1]];
    endtask

    task automatic push(int i, logic [31:0] d);
        fmem[i][(fhead[i] + fcnt[i]) % 512] = d;
        fcnt[i]++;
        drive();
    endtask

    task automatic compare_dut(int i, logic rd, logic [4:0] rq, logic [31:0] d,
                               logic dp, logic [15:0] pc, logic [7:0] dc);
        check($sformatf("d%0d.rdreq", i), 32'(rd), 32'(m_rd[i]));
        check($sformatf("d%0d.req", i), 32'(rq), 32'(m_req[i]));
        check($sformatf("d%0d.data_out", i), d, m_data[i]);
        check($sformatf("d%0d.drop_pulse", i), 32'(dp), 32'(m_drop[i]));
        check($sformatf("d%0d.pkt_cnt", i), 32'(pc), 32'(m_pkt[i]));
        check($sformatf("d%0d.drop_cnt", i), 32'(dc), 32'(m_dcnt[i]));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_update(0, gnt0);
        model_update(1, gnt1);
        @(negedge clk);
        cyc++;
        compare_dut(0, rdreq0, req0, data_out0, drop_pulse0, pkt_cnt0, drop_cnt0);
        compare_dut(1, rdreq1, req1, data_out1, drop_pulse1, pkt_cnt1, drop_cnt1);
        if (rdreq0) begin
            rd_seen[0]++;
            if (capture) begin
                cap_req.push_back(req0);
                cap_cyc.push_back(cyc);
            end
        end
        if (rdreq1) rd_seen[1]++;
        if (drop_pulse1) drop_seen[1]++;
        drive();
    endtask

    task automatic run_until_idle(int i, int budget, string tag);
        int n;
        n = 0;
        while (!(fcnt[i] == 0 && !m_hold[i] && !m_rd[i])) begin
            if (n >= budget) begin
                check(tag, 32'd1, 32'd0);
                return;
            end
            step();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base_rd, base_drop;
        xy_exp = '{c_e, c_w, c_n, c_s, c_l};
        for (int i = 0; i < 2; i++) begin
            fhead[i] = 0; fcnt[i] = 0; rd_seen[i] = 0; drop_seen[i] = 0;
            gmode[i] = 1; gfix[i] = 5'b0;
        end
        model_reset();
        drive();

        // Reset state
        repeat (3) step();
        check("rst.req0", 32'(req0), 32'd0);
        check("rst.rdreq1", 32'(rdreq1), 32'd0);
        check("rst.data_out0", data_out0, 32'd0);
        reset_n = 1'b1;
        step();

        // XY routing from (1,1)
        base_rd = rd_seen[0];
        capture = 1'b1;
        cap_req.delete();
        for (int k = 0; k < 5; k++) push(0, mkpkt(xy_dx[k], xy_dy[k]));
        run_until_idle(0, 60, "xy.timeout");
        capture = 1'b0;
        check("xy.rdreq_pulses", 32'(rd_seen[0] - base_rd), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < cap_req.size())
                check($sformatf("xy.req[%0d]", k), 32'(cap_req[k]), 32'(xy_exp[k]));
        end

        // YX routing: (2,3) goes north first; first-load latency
        gmode[1] = 2; gfix[1] = 5'b0;
        push(1, mkpkt(2, 3));
        step();
        check("yx.req_north", 32'(req1), 32'(c_n));
        check("yx.rdreq_first", 32'(rdreq1), 32'd1);
        step();
        check("yx.rdreq_pulse_end", 32'(rdreq1), 32'd0);
        gmode[1] = 1;
        drive();
        run_until_idle(1, 10, "yx.timeout");

        // Back-to-back: four packets, grant always matches
        base = int'(m_pkt[0]);
        base_rd = rd_seen[0];
        capture = 1'b1;
        cap_req.delete();
        cap_cyc.delete();
        for (int k = 0; k < 4; k++) push(0, mkpkt($urandom_range(0, 3), $urandom_range(0, 3)));
        run_until_idle(0, 40, "b2b.timeout");
        capture = 1'b0;
        check("b2b.rdreq_pulses", 32'(rd_seen[0] - base_rd), 32'd4);
        for (int k = 1; k < cap_cyc.size(); k++)
            check($sformatf("b2b.spacing[%0d]", k), 32'(cap_cyc[k] - cap_cyc[k-1]), 32'd2);
        check("b2b.pkt_cnt", 32'(pkt_cnt0), 32'((base + 4) & 16'hFFFF));
        check("b2b.req_idle", 32'(req0), 32'd0);

        // Grant mismatch held for five cycles, then matching grant
        base = int'(m_pkt[0]);
        gmode[0] = 2; gfix[0] = c_n;
        push(0, mkpkt(3, 1));
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            check("mm.req_held", 32'(req0), 32'(c_e));
        end
        gmode[0] = 1;
        drive();
        step();
        check("mm.req_released", 32'(req0), 32'd0);
        check("mm.pkt_cnt", 32'(pkt_cnt0), 32'((base + 1) & 16'hFFFF));

        // Out-of-mesh drops on the 3-column instance, saturating counter
        base_rd = rd_seen[1];
        base_drop = drop_seen[1];
        gmode[1] = 0;
        for (int k = 0; k < 260; k++) begin
            fmem[1][(fhead[1] + fcnt[1]) % 512] = mkpkt(3, $urandom_range(0, 3));
            fcnt[1]++;
        end
        drive();
        run_until_idle(1, 700, "drop.timeout");
        check("drop.pulses", 32'(drop_seen[1] - base_drop), 32'd260);
        check("drop.rdreq_pulses", 32'(rd_seen[1] - base_rd), 32'd260);
        check("drop.cnt_sat", 32'(drop_cnt1), 32'd255);
        check("drop.req_zero", 32'(req1), 32'd0);

        // Random traffic with random grants on both instances
        gmode[0] = 0; gmode[1] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 99) < 35 && fcnt[i] < 400)
                    push(i, mkpkt($urandom_range(0, 3), $urandom_range(0, 3)));
            step();
        end
        gmode[0] = 1; gmode[1] = 1;
        drive();
        run_until_idle(0, 1000, "rand.drain0");
        run_until_idle(1, 1000, "rand.drain1");

        // Asynchronous reset in the middle of a hold
        gmode[0] = 2; gfix[0] = 5'b0;
        push(0, mkpkt(0, 1));
        step();
        step();
        check("rst2.holding", 32'(req0), 32'(c_w));
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst2.req0", 32'(req0), 32'd0);
        check("rst2.rdreq0", 32'(rdreq0), 32'd0);
        check("rst2.data_out0", data_out0, 32'd0);
        check("rst2.pkt_cnt0", 32'(pkt_cnt0), 32'd0);
        check("rst2.drop_cnt1", 32'(drop_cnt1), 32'd0);
        base_rd = rd_seen[0];
        @(negedge clk);
        push(0, mkpkt(1, 0));
        repeat (3) step();
        check("rst2.no_rdreq", 32'(rd_seen[0] - base_rd), 32'd0);
        reset_n = 1'b1;
        gmode[0] = 1;
        drive();
        step();
        check("rst2.reload_req", 32'(req0), 32'(c_s));
        check("rst2.reload_rdreq", 32'(rdreq0), 32'd1);
        run_until_idle(0, 20, "rst2.drain");
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xy_route_dispatch.md
# xy_route_dispatch

Parametrised output-dispatch stage of a mesh NoC router. It pops packets from the router's show-ahead input FIFO and computes the destination direction by dimension-ordered routing (XY or YX, selectable). It presents each packet with a one-hot request to the crossbar/arbiter and holds it until the matching grant arrives. It supersedes the fixed 2-bit-coordinate, 32-bit dispatcher with generic widths, back-to-back dispatch, out-of-mesh packet dropping and status counters.

## Interface
- DW, 32, packet width
- CW, 2, width of each coordinate field (X and Y)
- X_LSB, 0, bit position of destination X field in the packet
- Y_LSB, 2, bit position of destination Y field (CW bits each)
- POS_X, 1, this router's X coordinate
- POS_Y, 1, this router's Y coordinate
- MESH_X, 4, number of columns; valid X is 0..MESH_X-1
- MESH_Y, 4, number of rows; valid Y is 0..MESH_Y-1
- YX_MODE, 0, 0 = route X first, 1 = route Y first

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- fifo_data  in  DW  FIFO head word, valid while fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- rdreq  out  1  FIFO pop, registered, one-cycle pulse per packet
- data_out  out  DW  held packet, valid while req≠0
- req  out  5  one-hot request {L,N,E,S,W} = bits {4,3,2,1,0}
- gnt  in  5  one-hot grant from the arbiter
- drop_pulse  out  1  one-cycle pulse when a packet is dropped
- pkt_cnt  out  16  dispatched-packet count, wraps
- drop_cnt  out  8  dropped-packet count, saturates at 255

## Operation
- States:
  - IDLE: no packet held.
  - HOLD: packet held in data_out, req asserted.
- Load condition: fifo_empty=0 and rdreq=0 and (state=IDLE, or state=HOLD with gnt==req this cycle). While rdreq=1 the head word is stale, so a load is never permitted then.
- On load:
  - data_out<=fifo_data and rdreq<=1 for the next cycle.
  - Let dx = fifo_data[X_LSB+:CW], dy = fifo_data[Y_LSB+:CW], compared unsigned.
  - If dx≥MESH_X or dy≥MESH_Y: drop. req<=0, drop_pulse<=1, drop_cnt increments (saturating), state<=IDLE.
  - XY routing (YX_MODE=0):
    - dx>POS_X → E
    - dx<POS_X → W
    - else dy>POS_Y → N
    - else dy<POS_Y → S
    - else L
  - YX routing (YX_MODE=1): compare Y first (N/S), then X (E/W), else L.
  - Otherwise: req<=route one-hot, state<=HOLD.
- HOLD:
  - gnt==req completes the packet and pkt_cnt increments.
  - Next state is HOLD with the new packet if the load condition holds, else IDLE with req<=0 and data_out held.
  - gnt≠req (including other nonzero patterns) is ignored; req and data_out are unchanged.
- rdreq, drop_pulse: registered; cleared the cycle after assertion unless a new load/drop occurs.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, rdreq=0, req=0, data_out=0, drop_pulse=0, pkt_cnt=0, drop_cnt=0. Reset mid-HOLD discards the held packet with no rdreq.
- Latency: fifo_empty falls at edge n → req and data_out valid after edge n+1. rdreq is high for cycle n+1 to n+2.
- Grant sampled on the same edge it is seen. req drops, or changes to the next packet, at that edge.
- Back-to-back throughput: one packet per 2 cycles. Grant in the cycle rdreq=1 completes the packet, but the next load waits one cycle.
- pkt_cnt wraps 0xFFFF→0x0000; drop_cnt holds at 0xFF.
- A drop occupies one cycle; the FIFO is still popped.
- Simultaneous grant and empty FIFO → IDLE, req=0.

## Test plan
- Reset: assert reset_n=0 mid-HOLD → all outputs 0 immediately, no further rdreq; release → IDLE.
- XY routing, POS=(1,1): packets with (dx,dy) = (3,0),(0,3),(1,3),(1,0),(1,1) → req 00100, 00001, 01000, 00010, 10000 respectively, one rdreq pulse each.
- YX_MODE=1, POS=(1,1): packet (3,3) → req 01000 (N), not E.
- Back-to-back: FIFO holds 4 packets, gnt=req continuously → req updates every 2 cycles, 4 rdreq pulses, pkt_cnt=4, req=0 after the last grant.
- Grant mismatch: req=00100, drive gnt=01000 for 5 cycles then gnt=00100 → req held through the mismatch, released on the matching edge, pkt_cnt+1.
- Drop: MESH_X=3, packet dx=3 → drop_pulse for 1 cycle, rdreq pulse, req stays 0. 260 such packets → drop_cnt=255.
